// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_WORDX = 2'b11
    } size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam logic [3:0] BE_NONE     = 4'b0000;
    localparam logic [3:0] BE_ALL      = 4'b1111;
    localparam logic [3:0] BE_HI_HALF  = 4'b1100;
    localparam logic [3:0] BE_LO_HALF  = 4'b0011;
    localparam logic [3:0] BE_TOP_BYTE = 4'b1000;

    typedef struct packed {
        logic        mem2reg;
        logic        regwr;
        logic [4:0]  rw;
        logic [31:0] result;
        logic [31:0] storedata;
        logic        memrd;
        logic        memwr;
        size_e       size;
        logic        signext;
        logic [1:0]  fpoint;
        logic [31:0] delayslot2;
        logic        jal;
    } mreg_t;

    function automatic logic is_misaligned(size_e size, logic [1:0] a);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return a[0];
            default: return a != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the memory stage and data memory.
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_rdata, dmem_ready
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_rdata, dmem_ready
    );
endinterface

// File: rtl/mem_align.sv
// Big-endian store lane replication / byte enables and load extraction / extension.
module mem_align
    import mem_stage_pkg::*;
(
    input  size_e       size_i,
    input  logic        signext_i,
    input  logic [1:0]  a_i,
    input  logic [31:0] sd_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_o,
    output logic [31:0] ldata_o,
    output logic        misalign_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        // {~a, 3'b000} == 8*(3-a): byte 0 lives in the top lane
        byte_v  = rdata_i[{~a_i, 3'b000} +: 8];
        half_v  = (a_i == 2'b00) ? rdata_i[31:16] : rdata_i[15:0];
        wdata_o = sd_i;
        be_o    = BE_ALL;
        ldata_o = rdata_i;
        case (size_i)
            SZ_BYTE: begin
                wdata_o = {4{sd_i[7:0]}};
                be_o    = BE_TOP_BYTE >> a_i;
                ldata_o = {{24{signext_i & byte_v[7]}}, byte_v};
            end
            SZ_HALF: begin
                wdata_o = {2{sd_i[15:0]}};
                be_o    = (a_i == 2'b00) ? BE_HI_HALF : BE_LO_HALF;
                ldata_o = {{16{signext_i & half_v[15]}}, half_v};
            end
            default: begin
                wdata_o = sd_i;
                be_o    = BE_ALL;
                ldata_o = rdata_i;
            end
        endcase
        misalign_o = is_misaligned(size_i, a_i);
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: M register, dmem handshake FSM with timeout,
// load alignment, and write-back outputs.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_mem2reg,
    input  logic        ex_regwr,
    input  logic [4:0]  ex_rw,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_storedata,
    input  logic        ex_memrd,
    input  logic        ex_memwr,
    input  logic [1:0]  ex_size,
    input  logic        ex_signext,
    input  logic [1:0]  ex_fpoint,
    input  logic [31:0] ex_delayslot2,
    input  logic        ex_jal,
    mem_stage_if.master dbus,
    output logic        mem_stall,
    output logic        mem_misalign,
    output logic        mem_fault,
    output logic        mem2reg,
    output logic        regwr,
    output logic        jal,
    output logic [4:0]  rw,
    output logic [1:0]  fpoint,
    output logic [31:0] dmem,
    output logic [31:0] execresult,
    output logic [31:0] delayslot2
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

    mreg_t           m_q, m_d;
    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            mem_op, mis, mis_raw;
    logic            req, stall, fault, done;
    logic [31:0]     st_wdata, ld_data;
    logic [3:0]      st_be;

    always_comb begin
        m_d.mem2reg    = ex_mem2reg;
        m_d.regwr      = ex_regwr;
        m_d.rw         = ex_rw;
        m_d.result     = ex_result;
        m_d.storedata  = ex_storedata;
        m_d.memrd      = ex_memrd;
        m_d.memwr      = ex_memwr;
        m_d.size       = size_e'(ex_size);
        m_d.signext    = ex_signext;
        m_d.fpoint     = ex_fpoint;
        m_d.delayslot2 = ex_delayslot2;
        m_d.jal        = ex_jal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q     <= '0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            if (!stall) m_q <= m_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    mem_align u_align (
        .size_i     (m_q.size),
        .signext_i  (m_q.signext),
        .a_i        (m_q.result[1:0]),
        .sd_i       (m_q.storedata),
        .rdata_i    (dbus.dmem_rdata),
        .wdata_o    (st_wdata),
        .be_o       (st_be),
        .ldata_o    (ld_data),
        .misalign_o (mis_raw)
    );

    assign mem_op = m_q.memrd | m_q.memwr;
    assign mis    = mem_op & mis_raw;

    // Timeout is checked before ready in WAIT so the abort cycle has no request
    // and a late ready is ignored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req     = 1'b0;
        stall   = 1'b0;
        fault   = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_op && !mis) begin
                    req = 1'b1;
                    if (dbus.dmem_ready) begin
                        done = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = ST_WAIT;
                        cnt_d   = CW'(1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_MAX) begin
                    fault   = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    req = 1'b1;
                    if (dbus.dmem_ready) begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        stall = 1'b1;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign dbus.dmem_req   = req;
    assign dbus.dmem_we    = m_q.memwr;
    assign dbus.dmem_addr  = {m_q.result[31:2], 2'b00};
    assign dbus.dmem_wdata = st_wdata;
    assign dbus.dmem_be    = req ? st_be : BE_NONE;

    assign mem_stall    = stall;
    assign mem_misalign = mis;
    assign mem_fault    = fault;
    assign mem2reg      = m_q.mem2reg;
    assign regwr        = m_q.regwr & ~stall & ~mis & ~fault;
    assign jal          = m_q.jal;
    assign rw           = m_q.rw;
    assign fpoint       = m_q.fpoint;
    assign dmem         = (done && m_q.memrd) ? ld_data : '0;
    assign execresult   = m_q.result;
    assign delayslot2   = m_q.delayslot2;

endmodule
